io_event_queue: RTL and testbench
=================================

IO_EVENT_QUEUE -- requirements
Module: io_event_queue

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of event input channels (1..32).
REQ-002 SHALL have parameter DEPTH, default 32, queue entries (power of 2, >=2).
REQ-003 SHALL have parameter TS_WIDTH, default 16, timestamp width (0 = no timestamp field).
REQ-004 SHALL have parameter DROP_W, default 8, dropped-event counter width.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port ev_in  input  NUM_CH  single-cycle event pulses, e.g. from the debounced buttons and rotary decoder.
REQ-008 SHALL have port ev_mask  input  NUM_CH  per-channel enable; 1 = channel may enqueue.
REQ-009 SHALL have port rd_en  input  1  pop request from the CPU side.
REQ-010 SHALL have port dout  output  TS_WIDTH+NUM_CH  head entry {timestamp, channel bits}.
REQ-011 SHALL have port empty  output  1  queue holds no entries.
REQ-012 SHALL have port full  output  1  queue holds DEPTH entries.
REQ-013 SHALL have port level  output  clog2(DEPTH)+1  current occupancy.
REQ-014 SHALL have port overflow  output  1  sticky flag: at least one event dropped.
REQ-015 SHALL have port drop_count  output  DROP_W  saturating count of dropped entries.
REQ-016 SHALL have port clr_ovf  input  1  clears overflow and drop_count.

Function
REQ-017 SHALL run a free-running TS_WIDTH-bit timestamp counter, +1 per cycle, wrapping from all-ones to 0.
REQ-018 SHALL form a candidate entry each cycle as {timestamp, ev_in & ev_mask}; enqueue request = OR of masked bits.
REQ-019 SHALL pack all channels asserted in the same cycle into one entry, never separate entries.
REQ-020 SHALL write an enqueue request whose cycle is N so that it is visible (empty=0 if previously empty, dout valid) in cycle N+1.
REQ-021 SHALL present the head entry on dout combinationally from storage (first-word-fall-through) whenever empty=0.
REQ-022 SHALL pop the head on rd_en=1 with empty=0; rd_en with empty=1 SHALL be ignored with no state change.
REQ-023 SHALL accept an enqueue while full when a valid pop occurs in the same cycle; level stays DEPTH.
REQ-024 SHALL, on enqueue with full=1 and no pop, drop the entry, set overflow, and increment drop_count, saturating at all-ones.
REQ-025 SHALL, on simultaneous enqueue and pop with 0<level<DEPTH, leave level unchanged.
REQ-026 SHALL give clr_ovf priority over a same-cycle drop: both clear, the drop is not counted.
REQ-027 SHALL wrap read and write pointers modulo DEPTH; full/empty derived from an extra pointer MSB or the level counter.
REQ-028 SHALL keep entries in strict arrival order.
REQ-029 SHALL ignore ev_mask changes for entries already queued.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, set level=0, empty=1, full=0, overflow=0, drop_count=0, timestamp=0, pointers=0.
REQ-031 SHALL discard queued entries and any same-cycle enqueue or pop when rst=1 mid-operation; dout is don't-care while empty.
REQ-032 SHALL enqueue events arriving in the first cycle after rst deasserts normally, with timestamp 0.

Structure
REQ-033 SHALL place entry-width and level-width computation functions, and channel index constants (center, north, east, south, west, rotary push, rotary event, rotary left), in a shared package.
REQ-034 SHALL use one sub-module, event_fifo_core, holding storage, pointers and level; io_event_queue holds masking, timestamp, drop logic.
REQ-035 SHALL be 120-400 lines RTL total, no vendor primitives.

Verification
REQ-036 SHALL test: NUM_CH=8, reset, ev_in=8'h05 mask=8'hFF at cycle 3 -> cycle 4 empty=0, dout={16'd3,8'h05}, level=1.
REQ-037 SHALL test: ev_in=8'h81 mask=8'h01 -> dout channel bits 8'h01; mask=8'h00 -> nothing enqueued, empty stays 1.
REQ-038 SHALL test: DEPTH=4, 6 events no reads -> full=1, level=4, drop_count=2, overflow=1; then clr_ovf -> both 0.
REQ-039 SHALL test: full queue, event plus rd_en same cycle -> level stays 4, drop_count unchanged, oldest entry removed, new entry last.
REQ-040 SHALL test: rd_en on empty -> no change; TS_WIDTH=4, event at cycle 17 -> timestamp field 4'd1 (wrap).
REQ-041 SHALL test: 3 entries queued, rst pulse -> next cycle empty=1, level=0, overflow=0; following event has timestamp 0.

Source files
------------

// File: rtl/io_event_queue_pkg.sv
// Shared definitions for the IO event queue: channel indices and width helpers.
package io_event_queue_pkg;

    // Channel bit positions for the front-panel event sources
    localparam int CH_CENTER   = 0;
    localparam int CH_NORTH    = 1;
    localparam int CH_EAST     = 2;
    localparam int CH_SOUTH    = 3;
    localparam int CH_WEST     = 4;
    localparam int CH_ROT_PUSH = 5;
    localparam int CH_ROT_EVT  = 6;
    localparam int CH_ROT_LEFT = 7;

    // One queue entry is {timestamp, channel bits}
    function automatic int entry_width(input int ts_w, input int num_ch);
        return ts_w + num_ch;
    endfunction

    // Occupancy needs one extra bit so that DEPTH itself is representable
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/event_fifo_core.sv
// First-word-fall-through FIFO: storage, wrapping pointers and occupancy.
module event_fifo_core
    import io_event_queue_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = 32,
    localparam int LVL_W = level_width(DEPTH),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [LVL_W-1:0] level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             rd_ok, wr_ok;

    assign empty_o   = (level_q == '0);
    assign full_o    = (level_q == LVL_W'(DEPTH));
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // A pop only counts when there is something to pop; a write into a full
    // queue is only accepted when the same-cycle pop frees a slot.
    assign rd_ok = rd_en_i && !empty_o;
    assign wr_ok = wr_en_i && (!full_o || rd_ok);

    // Next pointers (power-of-two depth, so natural wrap) and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({wr_ok, rd_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Entry storage; contents are don't-care while empty, so no reset
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/io_event_queue.sv
// Timestamped event queue: masks channel pulses, stamps them, queues them,
// and tracks entries lost to a full queue.
module io_event_queue
    import io_event_queue_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int DEPTH    = 32,
    parameter int TS_WIDTH = 16,
    parameter int DROP_W   = 8
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_CH-1:0]                         ev_in,
    input  logic [NUM_CH-1:0]                         ev_mask,
    input  logic                                      rd_en,
    output logic [entry_width(TS_WIDTH, NUM_CH)-1:0]  dout,
    output logic                                      empty,
    output logic                                      full,
    output logic [level_width(DEPTH)-1:0]             level,
    output logic                                      overflow,
    output logic [DROP_W-1:0]                         drop_count,
    input  logic                                      clr_ovf
);

    localparam int EW = entry_width(TS_WIDTH, NUM_CH);

    logic [NUM_CH-1:0] ev_m;
    logic [EW-1:0]     cand;
    logic              enq, pop, drop;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    // All channels firing together share one entry
    assign ev_m = ev_in & ev_mask;
    assign enq  = |ev_m;

    generate
        if (TS_WIDTH > 0) begin : g_ts
            logic [TS_WIDTH-1:0] ts_q;
            // Free-running timestamp, wraps naturally
            always_ff @(posedge clk) begin
                if (rst) ts_q <= '0;
                else     ts_q <= ts_q + TS_WIDTH'(1);
            end
            assign cand = {ts_q, ev_m};
        end else begin : g_nots
            assign cand = ev_m;
        end
    endgenerate

    event_fifo_core #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (enq),
        .wr_data_i (cand),
        .rd_en_i   (rd_en),
        .rd_data_o (dout),
        .empty_o   (empty),
        .full_o    (full),
        .level_o   (level)
    );

    // An entry is lost only when full and no same-cycle pop makes room
    assign pop  = rd_en && !empty;
    assign drop = enq && full && !pop;

    // Overflow bookkeeping; a clear wins over a same-cycle drop
    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (clr_ovf) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
        end
    end

    // Overflow state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    assign overflow   = ovf_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_io_event_queue.sv
// Directed self-checking bench for io_event_queue.
module tb_io_event_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ev_in = '0, ev_mask = 8'hFF;
    logic        rd_en = 1'b0, clr_ovf = 1'b0;
    logic [23:0] dout;
    logic        empty, full, overflow;
    logic [2:0]  level;
    logic [7:0]  drop_count;

    logic        rst_b = 1'b1;
    logic [7:0]  ev_b = '0, mask_b = 8'hFF;
    logic        rd_b = 1'b0, clr_b = 1'b0;
    logic [11:0] dout_b;
    logic        empty_b, full_b, ovf_b;
    logic [2:0]  level_b;
    logic [7:0]  drop_b;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    io_event_queue #(.NUM_CH(8), .DEPTH(4), .TS_WIDTH(16), .DROP_W(8)) dut (
        .clk(clk), .rst(rst), .ev_in(ev_in), .ev_mask(ev_mask), .rd_en(rd_en),
        .dout(dout), .empty(empty), .full(full), .level(level),
        .overflow(overflow), .drop_count(drop_count), .clr_ovf(clr_ovf)
    );

    io_event_queue #(.NUM_CH(8), .DEPTH(4), .TS_WIDTH(4), .DROP_W(8)) dut_b (
        .clk(clk), .rst(rst_b), .ev_in(ev_b), .ev_mask(mask_b), .rd_en(rd_b),
        .dout(dout_b), .empty(empty_b), .full(full_b), .level(level_b),
        .overflow(ovf_b), .drop_count(drop_b), .clr_ovf(clr_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        // Reset
        step(); step();
        rst = 1'b0; rst_b = 1'b0;
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);

        // Event at cycle 3, visible at cycle 4
        step(); step(); step();
        ev_in = 8'h05; ev_mask = 8'hFF;
        step();
        ev_in = 8'h00;
        chk("ev3_empty", 64'(empty), 64'd0);
        chk("ev3_dout", 64'(dout), 64'h000305);
        chk("ev3_level", 64'(level), 64'd1);

        // Pop it
        rd_en = 1'b1; step(); rd_en = 1'b0;
        chk("pop_empty", 64'(empty), 64'd1);

        // Masking: only channel 0 survives; then fully masked event plus pop
        ev_in = 8'h81; ev_mask = 8'h01; step();
        chk("mask_chan", 64'(dout[7:0]), 64'h01);
        chk("mask_ts", 64'(dout[23:8]), 64'd5);
        ev_in = 8'h81; ev_mask = 8'h00; rd_en = 1'b1; step();
        ev_in = 8'h00; ev_mask = 8'hFF; rd_en = 1'b0;
        chk("mask0_empty", 64'(empty), 64'd1);
        chk("mask0_level", 64'(level), 64'd0);

        // Pop on empty does nothing
        rd_en = 1'b1; step(); rd_en = 1'b0;
        chk("rdempty_empty", 64'(empty), 64'd1);
        chk("rdempty_level", 64'(level), 64'd0);
        chk("rdempty_ovf", 64'(overflow), 64'd0);

        // Six events into depth 4: two dropped
        for (int i = 0; i < 6; i++) begin
            ev_in = 8'h01 << i; step();
        end
        ev_in = 8'h00;
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_level", 64'(level), 64'd4);
        chk("fill_drop", 64'(drop_count), 64'd2);
        chk("fill_ovf", 64'(overflow), 64'd1);
        chk("fill_head", 64'(dout[7:0]), 64'h01);

        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        chk("clr_ovf", 64'(overflow), 64'd0);
        chk("clr_drop", 64'(drop_count), 64'd0);
        chk("clr_level", 64'(level), 64'd4);

        // Clear beats a same-cycle drop
        ev_in = 8'h40; step();
        chk("drop1_ovf", 64'(overflow), 64'd1);
        chk("drop1_cnt", 64'(drop_count), 64'd1);
        ev_in = 8'h40; clr_ovf = 1'b1; step();
        ev_in = 8'h00; clr_ovf = 1'b0;
        chk("clrprio_ovf", 64'(overflow), 64'd0);
        chk("clrprio_cnt", 64'(drop_count), 64'd0);

        // Full queue: event plus pop in the same cycle
        ev_in = 8'hAA; rd_en = 1'b1; step();
        ev_in = 8'h00;
        chk("fullrw_level", 64'(level), 64'd4);
        chk("fullrw_drop", 64'(drop_count), 64'd0);
        chk("fullrw_head", 64'(dout[7:0]), 64'h02);
        step(); chk("order_2", 64'(dout[7:0]), 64'h04);
        step(); chk("order_3", 64'(dout[7:0]), 64'h08);
        step(); chk("order_4", 64'(dout[7:0]), 64'hAA);
        step(); rd_en = 1'b0;
        chk("drain_empty", 64'(empty), 64'd1);

        // Drop counter saturates
        ev_in = 8'h01;
        for (int i = 0; i < 304; i++) step();
        ev_in = 8'h00;
        chk("sat_drop", 64'(drop_count), 64'hFF);
        chk("sat_ovf", 64'(overflow), 64'd1);

        // Three entries queued, then reset with same-cycle enqueue and pop
        rd_en = 1'b1; step(); rd_en = 1'b0;
        chk("pre_rst_level", 64'(level), 64'd3);
        rst = 1'b1; ev_in = 8'h01; rd_en = 1'b1; step();
        rst = 1'b0; ev_in = 8'h00; rd_en = 1'b0;
        chk("mrst_empty", 64'(empty), 64'd1);
        chk("mrst_level", 64'(level), 64'd0);
        chk("mrst_ovf", 64'(overflow), 64'd0);
        chk("mrst_drop", 64'(drop_count), 64'd0);
        ev_in = 8'h10; step(); ev_in = 8'h00;
        chk("post_rst_dout", 64'(dout), 64'h000010);

        // 4-bit timestamp wraps: cycle 17 stamps as 1
        rst_b = 1'b1; step(); rst_b = 1'b0;
        for (int i = 0; i < 17; i++) step();
        ev_b = 8'h01; step(); ev_b = 8'h00;
        chk("wrap_dout", 64'(dout_b), 64'h101);
        chk("wrap_level", 64'(level_b), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
